// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage integer unit with a valid/ready handshake.
// Base ALU ops complete in one cycle; the M-extension multiply/divide group
// runs an iterative radix-2 datapath for XLEN cycles. Division by zero and
// signed-overflow divisions are resolved at accept time in one cycle.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            synchronous abort of in-flight/held operation
//   in_valid/ready   operation handshake (op, a, b captured on accept)
//   op[4:0]          op[4]=0: base ALU code in op[3:0]; op[4]=1: M funct3 in op[2:0]
//   a, b             operands (rs1, rs2)
//   out_valid/ready  result handshake
//   result, iszero   registered result and its zero flag
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            iszero
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_n, launch;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_r;
  logic              neg_r, sa_r;
  logic [XLEN-1:0]   d_r, hi, lo;

  logic              accept;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;

  // ---------------- base ALU ----------------
  assign shamt = b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op[3:0])
      4'd0: alu_res = a + b;
      4'd1: alu_res = a - b;
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = {{(XLEN-1){1'b0}}, a < b};
      4'd6: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd7: alu_res = a << shamt;
      4'd8: alu_res = a >> shamt;
      4'd9: alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // ---------------- M-group operand setup ----------------
  logic            is_div_in, a_sgn, b_sgn, sa, sb, divz, ovf, special;
  logic [XLEN-1:0] ma, mb, spec_res;

  always_comb begin
    is_div_in = op[2];
    a_sgn     = is_div_in ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_sgn     = is_div_in ? ~op[0] : (op[1:0] == 2'b01);
    sa        = a_sgn & a[XLEN-1];
    sb        = b_sgn & b[XLEN-1];
    ma        = sa ? -a : a;
    mb        = sb ? -b : b;
    divz      = is_div_in && (b == '0);
    ovf       = is_div_in && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special   = divz || ovf;
    spec_res  = '0;
    if (divz)     spec_res = op[1] ? a : '1;
    else if (ovf) spec_res = op[1] ? '0 : a;
  end

  // ---------------- iteration datapath ----------------
  // hi/lo hold the product accumulator (mul) or remainder/quotient (div);
  // lo starts as |a| and is shifted out as result bits shift in.
  logic [XLEN:0]     sum, t;
  logic              ge;
  logic [XLEN-1:0]   dr, hi_n, lo_n, q_s, r_s, fin;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, d_r} : '0);
    t   = {hi, lo[XLEN-1]};
    ge  = t >= {1'b0, d_r};
    // When ge holds the difference is below d_r, so the low XLEN bits suffice.
    dr  = t[XLEN-1:0] - d_r;
    if (f3_r[2]) begin
      hi_n = ge ? dr : t[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
    prod = {hi_n, lo_n};
    if (neg_r) prod = -prod;
    q_s = neg_r ? -lo_n : lo_n;
    r_s = sa_r ? -hi_n : hi_n;
    if (f3_r[2]) fin = f3_r[1] ? r_s : q_s;
    else         fin = (f3_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---------------- control FSM ----------------
  assign accept = in_valid && in_ready && !flush;
  assign launch = (op[4] && !special) ? BUSY : DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_n = launch;
        BUSY:    if (cnt == CNT_W'(1)) state_n = DONE;
        DONE:    if (accept) state_n = launch;
                 else if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    out_valid = (state == DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      f3_r   <= '0;
      neg_r  <= 1'b0;
      sa_r   <= 1'b0;
      d_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      iszero <= 1'b1;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      if (!op[4]) begin
        result <= alu_res;
        iszero <= (alu_res == '0);
      end else if (special) begin
        result <= spec_res;
        iszero <= (spec_res == '0);
      end else begin
        cnt   <= CNT_W'(XLEN);
        f3_r  <= op[2:0];
        neg_r <= sa ^ sb;
        sa_r  <= sa;
        d_r   <= mb;
        hi    <= '0;
        lo    <= ma;
      end
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        result <= fin;
        iszero <= (fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, iv, out_ready, cur;
  logic [4:0]  op;
  logic [63:0] a, b;
  logic        ir32, ov32, z32, ir64, ov64, z64;
  logic [31:0] r32;
  logic [63:0] r64;
  logic        rdy_m, ov_m, z_m;
  logic [63:0] res_m;

  assign rdy_m = cur ? ir64 : ir32;
  assign ov_m  = cur ? ov64 : ov32;
  assign z_m   = cur ? z64  : z32;
  assign res_m = cur ? r64  : {32'h0, r32};

  alu_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv & ~cur), .in_ready(ir32),
    .op(op), .a(a[31:0]), .b(b[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .iszero(z32));

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv & cur), .in_ready(ir64),
    .op(op), .a(a), .b(b), .out_valid(ov64), .out_ready(out_ready),
    .result(r64), .iszero(z64));

  typedef struct {
    logic        w64;
    logic [4:0]  op;
    logic [63:0] a, b, exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic w, input logic [4:0] o, input logic [63:0] va,
                              input logic [63:0] vb, input logic [63:0] e, input int l,
                              input string n);
    vec_t v;
    v.w64 = w; v.op = o; v.a = va; v.b = vb; v.exp = e; v.lat = l; v.name = n;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] o, input logic [63:0] va, input logic [63:0] vb);
    int n = 0;
    while (!rdy_m && n < 200) begin
      tick();
      n++;
    end
    check("in_ready before accept", {63'h0, rdy_m}, 64'd1);
    iv = 1'b1; op = o; a = va; b = vb;
    tick();
    iv = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 1;
    while (!ov_m && lat < 200) begin
      check({name, " in_ready while busy"}, {63'h0, rdy_m}, 64'd0);
      tick();
      lat++;
    end
  endtask

  task automatic run(input vec_t v);
    int lat;
    cur = v.w64;
    launch(v.op, v.a, v.b);
    wait_out(v.name, lat);
    check({v.name, " latency"}, 64'(lat), 64'(v.lat));
    check({v.name, " result"}, res_m, v.exp);
    check({v.name, " iszero"}, {63'h0, z_m}, {63'h0, v.exp == 64'h0});
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= ov_m;
      tick();
    end
    check(name, {63'h0, seen}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0; flush = 1'b0; iv = 1'b0; out_ready = 1'b1; cur = 1'b0;
    op = '0; a = '0; b = '0;

    //               w64  op        a                      b                      expected               lat name
    add(1'b0, 5'd0,  64'd5,                 64'd7,                 64'd12,                1,  "ADD 5+7");
    add(1'b0, 5'd1,  64'd3,                 64'd3,                 64'd0,                 1,  "SUB 3-3");
    add(1'b0, 5'd2,  64'hF0F0,              64'hFF00,              64'hF000,              1,  "AND");
    add(1'b0, 5'd3,  64'hF0F0,              64'hFF00,              64'hFFF0,              1,  "OR");
    add(1'b0, 5'd4,  64'hF0F0,              64'hFF00,              64'h0FF0,              1,  "XOR");
    add(1'b0, 5'd9,  64'h8000_0000,         64'h24,                64'hF800_0000,         1,  "SRA");
    add(1'b0, 5'd7,  64'd1,                 64'h21,                64'd2,                 1,  "SLL masked");
    add(1'b0, 5'd8,  64'h8000_0000,         64'd31,                64'd1,                 1,  "SRL");
    add(1'b0, 5'd6,  64'hFFFF_FFFF,         64'd1,                 64'd1,                 1,  "SLT");
    add(1'b0, 5'd5,  64'hFFFF_FFFF,         64'd1,                 64'd0,                 1,  "SLTU");
    add(1'b0, 5'd15, 64'd5,                 64'd7,                 64'd0,                 1,  "code15");
    add(1'b0, 5'd10, 64'd5,                 64'd7,                 64'd0,                 1,  "code10");
    add(1'b0, 5'h11, 64'hFFFF_FFFE,         64'd3,                 64'hFFFF_FFFF,         33, "MULH");
    add(1'b0, 5'h10, 64'hFFFF_FFFE,         64'd3,                 64'hFFFF_FFFA,         33, "MUL");
    add(1'b0, 5'h13, 64'hFFFF_FFFF,         64'hFFFF_FFFF,         64'hFFFF_FFFE,         33, "MULHU");
    add(1'b0, 5'h12, 64'd2,                 64'hFFFF_FFFF,         64'd1,                 33, "MULHSU");
    add(1'b0, 5'h14, 64'hFFFF_FFF9,         64'd2,                 64'hFFFF_FFFD,         33, "DIV -7/2");
    add(1'b0, 5'h16, 64'hFFFF_FFF9,         64'd2,                 64'hFFFF_FFFF,         33, "REM -7%2");
    add(1'b0, 5'h14, 64'd7,                 64'hFFFF_FFFE,         64'hFFFF_FFFD,         33, "DIV 7/-2");
    add(1'b0, 5'h16, 64'd7,                 64'hFFFF_FFFE,         64'd1,                 33, "REM 7%-2");
    add(1'b0, 5'h15, 64'd7,                 64'd0,                 64'hFFFF_FFFF,         1,  "DIVU by 0");
    add(1'b0, 5'h17, 64'd7,                 64'd0,                 64'd7,                 1,  "REMU by 0");
    add(1'b0, 5'h16, 64'h8000_0000,         64'hFFFF_FFFF,         64'd0,                 1,  "REM ovf");
    add(1'b0, 5'h14, 64'h8000_0000,         64'hFFFF_FFFF,         64'h8000_0000,         1,  "DIV ovf");
    add(1'b1, 5'h13, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, "MULHU64");
    add(1'b1, 5'h11, 64'h1_0000_0000,       64'h1_0000_0000,       64'd1,                 65, "MULH64");
    add(1'b1, 5'h10, 64'h1_0000_0000,       64'h1_0000_0000,       64'd0,                 65, "MUL64");
    add(1'b1, 5'h14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,               64'hFFFF_FFFF_FFFF_FFFD, 65, "DIV64");
    add(1'b1, 5'h16, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,               64'hFFFF_FFFF_FFFF_FFFF, 65, "REM64");
    add(1'b1, 5'h14, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "DIV64 ovf");

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready32",  {63'h0, ir32}, 64'd1);
    check("reset out_valid32", {63'h0, ov32}, 64'd0);
    check("reset result32",    {32'h0, r32},  64'd0);
    check("reset iszero32",    {63'h0, z32},  64'd1);
    check("reset in_ready64",  {63'h0, ir64}, 64'd1);
    check("reset out_valid64", {63'h0, ov64}, 64'd0);
    check("reset result64",    r64,           64'd0);
    check("reset iszero64",    {63'h0, z64},  64'd1);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run(tbl[i]);

    // Backpressure: result held, then consumed on the same edge a new op is accepted.
    cur = 1'b0;
    tick();
    out_ready = 1'b0;
    launch(5'h15, 64'd100, 64'd7);
    wait_out("DIVU bp", lat);
    check("DIVU bp latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      check("bp held valid",    {63'h0, ov_m},  64'd1);
      check("bp held result",   res_m,          64'd14);
      check("bp held in_ready", {63'h0, rdy_m}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    iv = 1'b1; op = 5'd0; a = 64'd1; b = 64'd1;
    #1;
    check("bp in_ready on consume", {63'h0, rdy_m}, 64'd1);
    tick();
    iv = 1'b0;
    check("b2b out_valid", {63'h0, ov_m}, 64'd1);
    check("b2b result",    res_m,         64'd2);
    tick();

    // Flush at cycle 10 of a multiply.
    launch(5'h10, 64'd3, 64'd5);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush in_ready",  {63'h0, rdy_m}, 64'd1);
    check("flush out_valid", {63'h0, ov_m},  64'd0);
    check("flush result kept", res_m,        64'd2);
    watch_no_valid("flush no out_valid", 40);

    // Accept presented together with flush is discarded.
    flush = 1'b1; iv = 1'b1; op = 5'd0; a = 64'd4; b = 64'd4;
    tick();
    flush = 1'b0; iv = 1'b0;
    check("flushed accept out_valid", {63'h0, ov_m}, 64'd0);
    check("flushed accept result",    res_m,         64'd2);

    // Async reset in the middle of BUSY.
    launch(5'h10, 64'd3, 64'd5);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst in_ready",  {63'h0, rdy_m}, 64'd1);
    check("midrst out_valid", {63'h0, ov_m},  64'd0);
    check("midrst result",    res_m,          64'd0);
    check("midrst iszero",    {63'h0, z_m},   64'd1);
    tick();
    rst_n = 1'b1;
    watch_no_valid("midrst no out_valid", 40);

    begin
      vec_t v;
      v.w64 = 1'b0; v.op = 5'd0; v.a = 64'd2; v.b = 64'd3; v.exp = 64'd5; v.lat = 1;
      v.name = "ADD after reset";
      run(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
